// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer between the MEM stage and data memory
// Circular FIFO of pending stores with word-granular load conflict detection.

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_be,
  input  logic [31:0]              st_pc,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     ld_conflict,
  input  logic                     dm_hold,
  output logic                     dm_we,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_wdata,
  output logic [3:0]               dm_be,
  output logic [31:0]              dm_pc,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [3:0]       be_d   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];

  logic push;
  logic pop;
  logic ld_addr_lsb_unused;

  // Byte offset within the word never participates in conflict checks.
  assign ld_addr_lsb_unused = ^ld_addr[1:0];

  assign empty    = (count_q == '0);
  assign st_ready = (count_q != CW'(DEPTH));
  assign dm_we    = !empty && !dm_hold;
  assign count    = count_q;

  assign push = st_valid && st_ready && (st_be != 4'b0000);
  assign pop  = dm_we;

  assign dm_addr  = empty ? 32'h0 : addr_q[head_q];
  assign dm_wdata = empty ? 32'h0 : data_q[head_q];
  assign dm_be    = empty ? 4'h0  : be_q[head_q];
  assign dm_pc    = empty ? 32'h0 : pc_q[head_q];

  // The head is still a conflict source in the cycle it is being written.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) begin
        ld_conflict = ld_valid;
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      be_d[i]   = be_q[i];
      pc_d[i]   = pc_q[i];
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = st_addr;
      data_d[tail_q]  = st_data;
      be_d[tail_q]    = st_be;
      pc_d[tail_q]    = st_pc;
      tail_d          = tail_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
        be_q[i]   <= be_d[i];
        pc_q[i]   <= pc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
// Expected writes are queued at acceptance and compared against the head outputs.

module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_be = '0;
  logic [31:0] st_pc = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_conflict;
  logic        dm_hold = 1'b0;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        empty;
  logic [2:0]  count;

  ent_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  logic m_pop;
  logic m_push;
  logic exp_conf;
  int   n;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_pc(st_pc),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .dm_hold(dm_hold), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_pc(dm_pc),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] pc);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    st_pc    = pc;
  endtask

  task automatic drain();
    int k;
    st_valid = 1'b0;
    dm_hold  = 1'b0;
    k = 0;
    while (!empty && k < 20) begin
      cyc();
      k++;
    end
    #1;
    chk("drain_empty", empty, 1'b1);
  endtask

  // Reference model: acceptance and retirement decided from the queue occupancy.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      n      = q.size();
      m_pop  = (n != 0) && !dm_hold;
      m_push = st_valid && (n != DEPTH) && (st_be != 4'b0000);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back({st_addr, st_data, st_be, st_pc});
    end
  end

  always @(negedge clk) begin
    exp_conf = 1'b0;
    foreach (q[i]) begin
      if (ld_valid && (q[i].addr[31:2] == ld_addr[31:2])) exp_conf = 1'b1;
    end
    chk("ld_conflict", ld_conflict, exp_conf);
    chk("st_ready", st_ready, q.size() != DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("count", count, q.size());
    chk("dm_we", dm_we, (q.size() != 0) && !dm_hold);
    if (q.size() != 0) begin
      chk("dm_addr", dm_addr, q[0].addr);
      chk("dm_wdata", dm_wdata, q[0].data);
      chk("dm_be", dm_be, q[0].be);
      chk("dm_pc", dm_pc, q[0].pc);
    end else begin
      chk("dm_addr_zero", dm_addr, 32'h0);
      chk("dm_wdata_zero", dm_wdata, 32'h0);
      chk("dm_be_zero", dm_be, 4'h0);
      chk("dm_pc_zero", dm_pc, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) cyc();
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 3'd0);
    chk("rst_dm_we", dm_we, 1'b0);
    #2 reset = 1'b0;

    // single store, latency one
    cyc();
    set_store(32'h10, 32'hDEADBEEF, 4'hF, 32'h1000);
    cyc();
    st_valid = 1'b0;
    #1;
    chk("t31_dm_we", dm_we, 1'b1);
    chk("t31_dm_addr", dm_addr, 32'h10);
    chk("t31_dm_wdata", dm_wdata, 32'hDEADBEEF);
    cyc();
    chk("t31_empty", empty, 1'b1);

    // fill under hold, fifth rejected
    dm_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_store(32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 32'h2000 + 32'(4 * i));
      if (i == 4) begin
        #1;
        chk("t32_st_ready", st_ready, 1'b0);
        chk("t32_count", count, 3'd4);
      end
      cyc();
    end
    st_valid = 1'b0;
    dm_hold  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      cyc();
      chk("t32_drain_count", count, 3'(k));
    end

    // word-granular load conflict
    dm_hold = 1'b1;
    set_store(32'h104, 32'h1234_5678, 4'h3, 32'h3000);
    cyc();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h106;
    #1 chk("t33_conf_same_word", ld_conflict, 1'b1);
    ld_addr = 32'h108;
    #1 chk("t33_conf_next_word", ld_conflict, 1'b0);
    ld_addr = 32'h106;
    dm_hold = 1'b0;
    #1 chk("t33_conf_popping_head", ld_conflict, 1'b1);
    cyc();
    chk("t33_conf_drained", ld_conflict, 1'b0);
    ld_valid = 1'b0;

    // simultaneous push/pop with wrap
    dm_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_store(32'h500 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, 32'h5000 + 32'(i));
      cyc();
    end
    dm_hold = 1'b0;
    for (int i = 2; i < 6; i++) begin
      set_store(32'h500 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'h1 << (i % 4), 32'h5000 + 32'(i));
      #1 chk("t34_count_steady", count, 3'd2);
      cyc();
    end
    st_valid = 1'b0;
    #1 chk("t34_count_after", count, 3'd2);
    drain();

    // asynchronous reset mid-cycle drops pending stores
    dm_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_store(32'h600 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'hF, 32'h6000);
      cyc();
    end
    st_valid = 1'b0;
    #1 chk("t35_count_before", count, 3'd3);
    #2 reset = 1'b1;
    #1;
    chk("t35_count", count, 3'd0);
    chk("t35_empty", empty, 1'b1);
    chk("t35_dm_addr", dm_addr, 32'h0);
    chk("t35_dm_wdata", dm_wdata, 32'h0);
    chk("t35_st_ready", st_ready, 1'b1);
    dm_hold = 1'b0;
    #1 chk("t35_dm_we", dm_we, 1'b0);
    cyc();
    #2 reset = 1'b0;
    repeat (3) cyc();
    chk("t35_no_write", dm_we, 1'b0);

    // zero byte-enable store is swallowed
    set_store(32'h700, 32'hFFFF_FFFF, 4'h0, 32'h7000);
    #1 chk("t36_st_ready", st_ready, 1'b1);
    cyc();
    st_valid = 1'b0;
    #1;
    chk("t36_count", count, 3'd0);
    chk("t36_dm_we", dm_we, 1'b0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = 32'h400 + 32'($urandom_range(0, 31));
      st_data  = $urandom;
      st_be    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      st_pc    = $urandom;
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 32'h400 + 32'($urandom_range(0, 31));
      dm_hold  = ($urandom_range(0, 2) == 0);
      cyc();
    end
    ld_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
